alu_iter_exec: RTL and testbench

// - Multi-cycle execute unit: consumes the 4-bit Operation code produced by the ALU controller, plus two operands.
// - Returns the result over a valid/ready handshake.
// - Logic, arithmetic, compare and equality ops complete in 1 cycle.
// - Shifts iterate 1 bit/cycle, which removes the 32-bit barrel shifter from the EX stage of area-constrained builds.
// - Sits between the ID/EX register and the EX/MEM register; the pipeline stalls while in_ready=0.

---
 rtl/alu_iter_exec.sv | 165 ++++++++++++++++
 tb/tb_alu_iter_exec.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: multi-cycle execute unit behind a valid/ready handshake.
// Logic, arithmetic, compare and equality ops take 1 cycle. Shifts step one
// bit per cycle, so latency is 1+shamt.
// Optional build macro: BARREL_SHIFT_EN. When it is defined, shifts are computed
// combinationally at accept and every op takes 1 cycle. Results are the same
// in both builds; only the timing differs.
module alu_iter_exec #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Illegal
);
    localparam int W = DATA_WIDTH;

`ifdef BARREL_SHIFT_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE, SHIFT} state_t;
`endif

    state_t               state, state_d;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic [W-1:0]         res_c;
    logic                 ill_c;
    logic [W-1:0]         result_q;
    logic                 zero_q;
    logic                 illegal_q;

`ifndef BARREL_SHIFT_EN
    logic [3:0]           op_q;
    logic [SHAMT_W-1:0]   cnt;
    logic [W-1:0]         work;
    logic [W-1:0]         step;
`endif

    assign shamt     = SrcB[SHAMT_W-1:0];
    assign is_shift  = (Operation == 4'b0100) || (Operation == 4'b1001) || (Operation == 4'b1101);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

    // Single-cycle result for the request presented at the inputs.
    always_comb begin
        res_c = '0;
        ill_c = 1'b0;
        case (Operation)
            4'b0000: res_c = SrcA & SrcB;
            4'b0001: res_c = SrcA | SrcB;
            4'b0010,
            4'b1100: res_c = SrcA + SrcB;
            4'b0011,
            4'b0111: res_c = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            4'b0101: res_c = SrcA ^ SrcB;
            4'b0110: res_c = SrcA - SrcB;
            4'b1000: res_c = {{(W-1){1'b0}}, (SrcA == SrcB)};
`ifdef BARREL_SHIFT_EN
            4'b0100: res_c = $signed(SrcA) >>> shamt;
            4'b1001: res_c = SrcA << shamt;
            4'b1101: res_c = SrcA >> shamt;
`else
            // Only reached as a final result when shamt==0; otherwise the
            // SHIFT state produces the value.
            4'b0100,
            4'b1001,
            4'b1101: res_c = SrcA;
`endif
            default: begin
                res_c = '0;
                ill_c = 1'b1;
            end
        endcase
    end

`ifndef BARREL_SHIFT_EN
    // One-bit shift of the working register in the captured direction.
    always_comb begin
        step = work;
        case (op_q)
            4'b0100: step = {work[W-1], work[W-1:1]};
            4'b1001: step = {work[W-2:0], 1'b0};
            default: step = {1'b0, work[W-1:1]};
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef BARREL_SHIFT_EN
                    state_d = DONE;
`else
                    if (is_shift && (shamt != '0)) state_d = SHIFT;
                    else                           state_d = DONE;
`endif
                end
            end
`ifndef BARREL_SHIFT_EN
            SHIFT:   if (cnt == SHAMT_W'(1)) state_d = DONE;
`endif
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. The result and Zero registers load only when the op finishes,
    // so intermediate shift values never appear on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifndef BARREL_SHIFT_EN
            op_q      <= '0;
            cnt       <= '0;
            work      <= '0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                illegal_q <= ill_c;
                if (state_d == DONE) begin
                    result_q <= res_c;
                    zero_q   <= (res_c == '0);
                end
`ifndef BARREL_SHIFT_EN
                op_q <= Operation;
                cnt  <= shamt;
                work <= SrcA;
`endif
            end
`ifndef BARREL_SHIFT_EN
            if (state == SHIFT) begin
                work <= step;
                cnt  <= cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    result_q <= step;
                    zero_q   <= (step == '0);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: directed spec cases plus random ops against a
// behavioural reference model.
module tb_alu_iter_exec;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    int checks = 0;
    int errors = 0;

    alu_iter_exec #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {illegal, result} from the op table with plain arithmetic.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b % 32);
        case (op)
            4'd0:  return {1'b0, a & b};
            4'd1:  return {1'b0, a | b};
            4'd2,
            4'd12: return {1'b0, a + b};
            4'd3,
            4'd7:  return {1'b0, (int'(a) < int'(b)) ? 32'd1 : 32'd0};
            4'd4:  return {1'b0, 32'(sa >>> sh)};
            4'd5:  return {1'b0, a ^ b};
            4'd6:  return {1'b0, a - b};
            4'd8:  return {1'b0, (a == b) ? 32'd1 : 32'd0};
            4'd9:  return {1'b0, a << sh};
            4'd13: return {1'b0, a >> sh};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef BARREL_SHIFT_EN
        return 1;
`else
        if (op == 4'd4 || op == 4'd9 || op == 4'd13) return 1 + int'(b % 32);
        return 1;
`endif
    endfunction

    // Issue one op, check latency, result, flags, hold under backpressure,
    // then complete the handshake and check the return to idle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [32:0] exp;
        int lat;
        exp = ref_alu(op, a, b);
        @(negedge clk);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // Operands are captured at accept; scramble them afterwards.
        in_valid = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(ref_lat(op, b)));
        chk({tag, ".result"}, ALUResult, exp[31:0]);
        chk({tag, ".zero"}, 32'(Zero), 32'(exp[31:0] == 32'd0));
        chk({tag, ".illegal"}, 32'(Illegal), 32'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_result"}, ALUResult, exp[31:0]);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Operation = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.result", ALUResult, 32'd0);
        chk("reset.zero", 32'(Zero), 32'd1);
        chk("reset.illegal", 32'(Illegal), 32'd0);
        reset = 1'b0;

        run_op("add", 4'b0010, 32'd5, 32'd7, 0);
        run_op("sub_zero", 4'b0110, 32'h1234, 32'h1234, 0);
        run_op("eq", 4'b1000, 32'd9, 32'd9, 1);
        run_op("sll31", 4'b1001, 32'd1, 32'd31, 0);
        run_op("sra4", 4'b0100, 32'h8000_0000, 32'h24, 0);
        run_op("slt_bp", 4'b0011, 32'hFFFF_FFFF, 32'd1, 5);
        run_op("srl0", 4'b1101, 32'hDEAD_BEEF, 32'h40, 0);

        // Reset in the middle of an SRL discards it with no out_valid pulse.
        @(negedge clk);
        Operation = 4'b1101; SrcA = 32'hFFFF_0000; SrcB = 32'd16; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset.out_valid", 32'(out_valid), 32'd0);
        chk("midreset.in_ready", 32'(in_ready), 32'd1);
        chk("midreset.result", ALUResult, 32'd0);
        chk("midreset.zero", 32'(Zero), 32'd1);
        repeat (20) begin
            @(posedge clk); #1;
            chk("midreset.no_pulse", 32'(out_valid), 32'd0);
        end
        run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
